serial_pattern_transmitter: RTL and testbench
=============================================

SERIAL_PATTERN_TRANSMITTER -- requirements
Module: serial_pattern_transmitter

Interface
REQ-001 The block SHALL have parameter MAX_LEN, default 8, giving the maximum pattern length in bits (legal range 2..16).
REQ-002 The block SHALL have parameter CNT_W, default 4, giving the width of the repeat-count input.
REQ-003 The block SHALL have port clk, input, 1, system clock; all state changes on rising edge.
REQ-004 The block SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 The block SHALL have port start, input, 1, transmit request, sampled on rising clk.
REQ-006 The block SHALL have port pattern, input, MAX_LEN, bits to send; only bits [len-1:0] are used.
REQ-007 The block SHALL have port len, input, 5, number of pattern bits to send per repetition.
REQ-008 The block SHALL have port repeat_n, input, CNT_W, number of repetitions.
REQ-009 The block SHALL have port gap_en, input, 1, inserts one idle cycle between repetitions.
REQ-010 The block SHALL have port a, output, 1, serial data bit.
REQ-011 The block SHALL have port a_valid, output, 1, high when a carries a pattern bit.
REQ-012 The block SHALL have port ready, output, 1, high when a start can be accepted.
REQ-013 The block SHALL have port busy, output, 1, high while a transfer is in progress.
REQ-014 The block SHALL have port done, output, 1, one-cycle pulse at end of transfer.

Function
REQ-015 The FSM SHALL have states IDLE, SEND, GAP and DONE.
REQ-016 ready SHALL be high only in IDLE; busy SHALL be high in SEND and GAP only.
REQ-017 start SHALL be accepted only when high at a rising edge with the FSM in IDLE; start in any other state SHALL be ignored, with no queuing.
REQ-018 On acceptance, pattern, effective len, effective repeat_n and gap_en SHALL be captured; later input changes SHALL not affect the transfer.
REQ-019 Effective len SHALL be min(len, MAX_LEN); effective repeat_n SHALL be 1 when repeat_n==0, else repeat_n.
REQ-020 If effective len==0 on acceptance, the FSM SHALL go IDLE->DONE directly, sending no bits.
REQ-021 Otherwise the FSM SHALL go IDLE->SEND; the first bit, pattern[len-1], SHALL appear on a with a_valid=1 in the cycle immediately after the accepting edge.
REQ-022 Bits SHALL be sent MSB-first, one per cycle: pattern[len-1] down to pattern[0], with no gaps within a repetition.
REQ-023 After bit 0 of a non-final repetition: if gap_en, the FSM SHALL go SEND->GAP for exactly one cycle (a=0, a_valid=0), then GAP->SEND; if not gap_en, it SHALL stay in SEND and restart at pattern[len-1] the next cycle.
REQ-024 After bit 0 of the final repetition, the FSM SHALL go SEND->DONE; in DONE, done=1, a=0 and a_valid=0 for exactly one cycle, and the next state SHALL be IDLE unconditionally.
REQ-025 start high during DONE SHALL be ignored; the earliest accepting edge is the first edge with the FSM in IDLE.
REQ-026 Total cycles from the accepting edge to the done pulse SHALL be len*reps + (gap_en ? reps-1 : 0) + 1.
REQ-027 a, a_valid and done SHALL be registered outputs (no combinational path from inputs); a SHALL be 0 whenever a_valid=0.
REQ-028 The bit index counter and the repetition counter SHALL never wrap; terminal counts SHALL be detected exactly, with no extra or missing bit at any boundary.

Reset
REQ-029 Asserting rst at any time, including mid-SEND or GAP, SHALL immediately force IDLE, a=0, a_valid=0, busy=0, done=0, ready=1, and clear all counters and captured registers.
REQ-030 After rst deasserts, the first rising edge with start=1 SHALL begin a fresh transfer; no partial transfer SHALL resume.

Verification
REQ-031 The bench SHALL check: pattern=6'b110011, len=6, repeat_n=1, gap_en=0 -> a=1,1,0,0,1,1 with a_valid=1 in cycles 1-6, done=1 in cycle 7, ready=1 in cycle 8.
REQ-032 The bench SHALL check: pattern=4'b1010, len=4, repeat_n=3, gap_en=0 -> 12 consecutive valid bits 101010101010, done in cycle 13; then gap_en=1 -> 1010,gap,1010,gap,1010, with a_valid=0 in cycles 5 and 10 and done in cycle 15.
REQ-033 The bench SHALL check: start pulsed again in cycles 2 and 7 of the first transfer -> both ignored, output identical to the first transfer, exactly one done pulse.
REQ-034 The bench SHALL check: rst asserted asynchronously in cycle 3 of a len=6 transfer -> a_valid and busy drop before the next edge; a later start sends the full pattern from pattern[len-1].
REQ-035 The bench SHALL check: len=0 -> no valid bits, done in cycle 1; len=20 with MAX_LEN=8 -> exactly 8 bits, MSB first.
REQ-036 The bench SHALL check: repeat_n=0 -> exactly one repetition.

Source files
------------

// File: rtl/serial_pattern_transmitter.sv
// Serial pattern transmitter: sends pattern[len-1:0] MSB-first, repeat_n times,
// with an optional single idle cycle between repetitions and a one-cycle done pulse.
module serial_pattern_transmitter #(
   parameter int unsigned MAX_LEN = 8,
   parameter int unsigned CNT_W   = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [MAX_LEN-1:0] pattern,
   input  logic [4:0]         len,
   input  logic [CNT_W-1:0]   repeat_n,
   input  logic               gap_en,
   output logic               a,
   output logic               a_valid,
   output logic               ready,
   output logic               busy,
   output logic               done
);

   localparam int unsigned IDX_W = $clog2(MAX_LEN);

   typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;

   state_t             state_q;
   logic [MAX_LEN-1:0] pat_q;
   logic [IDX_W-1:0]   top_q;
   logic [IDX_W-1:0]   idx_q;
   logic [CNT_W-1:0]   rep_q;
   logic               gap_q;
   logic               a_q;
   logic               a_valid_q;
   logic               ready_q;
   logic               busy_q;
   logic               done_q;

   // Effective request values, clamped at capture time
   logic [4:0]         eff_len;
   logic [IDX_W-1:0]   eff_top;
   logic [CNT_W-1:0]   eff_rep;

   assign eff_len = (len > 5'(MAX_LEN)) ? 5'(MAX_LEN) : len;
   assign eff_top = IDX_W'(eff_len - 5'd1);
   assign eff_rep = (repeat_n == '0) ? CNT_W'(1) : repeat_n;

   // idx_q is the index of the bit currently on a; rep_q counts repetitions left
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         pat_q     <= '0;
         top_q     <= '0;
         idx_q     <= '0;
         rep_q     <= '0;
         gap_q     <= 1'b0;
         a_q       <= 1'b0;
         a_valid_q <= 1'b0;
         ready_q   <= 1'b1;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         a_q       <= 1'b0;
         a_valid_q <= 1'b0;
         done_q    <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  pat_q   <= pattern;
                  top_q   <= eff_top;
                  idx_q   <= eff_top;
                  rep_q   <= eff_rep;
                  gap_q   <= gap_en;
                  ready_q <= 1'b0;
                  if (eff_len == 5'd0) begin
                     state_q <= DONE;
                     done_q  <= 1'b1;
                  end else begin
                     state_q   <= SEND;
                     busy_q    <= 1'b1;
                     a_q       <= pattern[eff_top];
                     a_valid_q <= 1'b1;
                  end
               end
            end
            SEND: begin
               if (idx_q != '0) begin
                  idx_q     <= idx_q - IDX_W'(1);
                  a_q       <= pat_q[idx_q - IDX_W'(1)];
                  a_valid_q <= 1'b1;
               end else if (rep_q == CNT_W'(1)) begin
                  state_q <= DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end else begin
                  rep_q <= rep_q - CNT_W'(1);
                  if (gap_q) begin
                     state_q <= GAP;
                  end else begin
                     idx_q     <= top_q;
                     a_q       <= pat_q[top_q];
                     a_valid_q <= 1'b1;
                  end
               end
            end
            GAP: begin
               state_q   <= SEND;
               idx_q     <= top_q;
               a_q       <= pat_q[top_q];
               a_valid_q <= 1'b1;
            end
            DONE: begin
               state_q <= IDLE;
               ready_q <= 1'b1;
            end
            default: begin
               state_q <= IDLE;
               ready_q <= 1'b1;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign a       = a_q;
   assign a_valid = a_valid_q;
   assign ready   = ready_q;
   assign busy    = busy_q;
   assign done    = done_q;

endmodule

// File: tb/tb_serial_pattern_transmitter.sv
// Directed bench for serial_pattern_transmitter: per-cycle expected outputs are
// queued when a transfer is launched and compared on every falling edge.
module tb_serial_pattern_transmitter;

   localparam int unsigned MAX_LEN = 8;
   localparam int unsigned CNT_W   = 4;

   logic               clk = 1'b0;
   logic               rst;
   logic               start;
   logic [MAX_LEN-1:0] pattern;
   logic [4:0]         len;
   logic [CNT_W-1:0]   repeat_n;
   logic               gap_en;
   logic               a;
   logic               a_valid;
   logic               ready;
   logic               busy;
   logic               done;

   always #5 clk = ~clk;

   serial_pattern_transmitter #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .pattern  (pattern),
      .len      (len),
      .repeat_n (repeat_n),
      .gap_en   (gap_en),
      .a        (a),
      .a_valid  (a_valid),
      .ready    (ready),
      .busy     (busy),
      .done     (done)
   );

   typedef struct packed {
      logic a;
      logic a_valid;
      logic done;
      logic ready;
      logic busy;
   } exp_t;

   exp_t  sb[$];
   exp_t  mon_e;
   int    total    = 0;
   int    passed   = 0;
   int    done_cnt = 0;
   int    cyc      = 0;
   string step     = "reset";

   task automatic check1(input string tag, input logic obs, input logic expv);
      total++;
      assert (obs === expv) passed++;
      else $error("FAIL %s/%s cyc=%0d observed=%b expected=%b", step, tag, cyc, obs, expv);
   endtask

   task automatic checkn(input string tag, input int obs, input int expv);
      total++;
      assert (obs === expv) passed++;
      else $error("FAIL %s/%s observed=%0d expected=%0d", step, tag, obs, expv);
   endtask

   function automatic exp_t mk(input logic av, input logic vv, input logic dv,
                               input logic rv, input logic bv);
      exp_t e;
      e.a = av; e.a_valid = vv; e.done = dv; e.ready = rv; e.busy = bv;
      return e;
   endfunction

   // Reference behaviour: bits MSB-first, optional gap, done, then idle/ready
   task automatic push_model(input logic [7:0] pat, input logic [4:0] ln,
                             input logic [3:0] rp, input logic gp, input int extra);
      int el;
      int nr;
      el = (int'(ln) > 8) ? 8 : int'(ln);
      nr = (rp == 4'd0) ? 1 : int'(rp);
      for (int r = 0; r < nr; r++) begin
         for (int i = el - 1; i >= 0; i--) sb.push_back(mk(pat[i], 1'b1, 1'b0, 1'b0, 1'b1));
         if (gp && (r < nr - 1)) sb.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
      end
      sb.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
      for (int k = 0; k <= extra; k++) sb.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         cyc++;
         if (done) done_cnt++;
         if (sb.size() != 0) begin
            mon_e = sb.pop_front();
            check1("a",       a,       mon_e.a);
            check1("a_valid", a_valid, mon_e.a_valid);
            check1("done",    done,    mon_e.done);
            check1("ready",   ready,   mon_e.ready);
            check1("busy",    busy,    mon_e.busy);
         end
      end
   end

   // Launch one transfer; s1/s2 are cycles in which a stray start is raised
   task automatic xfer(input logic [7:0] pat, input logic [4:0] ln, input logic [3:0] rp,
                       input logic gp, input int extra, input int s1, input int s2);
      int n;
      @(negedge clk); #1;
      pattern  = pat;
      len      = ln;
      repeat_n = rp;
      gap_en   = gp;
      start    = 1'b1;
      done_cnt = 0;
      cyc      = 0;
      push_model(pat, ln, rp, gp, extra);
      n = sb.size();
      for (int c = 1; c <= n; c++) begin
         @(negedge clk); #1;
         start = (c == s1) || (c == s2);
         if (c == 1) begin
            pattern  = ~pat;
            len      = 5'd1;
            repeat_n = 4'd2;
            gap_en   = ~gp;
         end
      end
      checkn("drained",  sb.size(), 0);
      checkn("done_cnt", done_cnt,  1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst      = 1'b1;
      start    = 1'b0;
      pattern  = '0;
      len      = 5'd0;
      repeat_n = '0;
      gap_en   = 1'b0;
      #12;
      check1("rst_a",       a,       1'b0);
      check1("rst_a_valid", a_valid, 1'b0);
      check1("rst_busy",    busy,    1'b0);
      check1("rst_done",    done,    1'b0);
      check1("rst_ready",   ready,   1'b1);
      @(negedge clk); #1 rst = 1'b0;

      step = "single6";   xfer(8'b0011_0011, 5'd6, 4'd1, 1'b0, 0, 0, 0);
      step = "rep3";      xfer(8'b0000_1010, 5'd4, 4'd3, 1'b0, 0, 0, 0);
      step = "rep3_gap";  xfer(8'b0000_1010, 5'd4, 4'd3, 1'b1, 0, 0, 0);
      step = "stray";     xfer(8'b0011_0011, 5'd6, 4'd1, 1'b0, 3, 2, 7);

      // Asynchronous reset in cycle 3 of a six-bit transfer
      step = "rst_mid";
      @(negedge clk); #1;
      pattern  = 8'b0010_1101;
      len      = 5'd6;
      repeat_n = 4'd1;
      gap_en   = 1'b0;
      start    = 1'b1;
      cyc      = 0;
      push_model(8'b0010_1101, 5'd6, 4'd1, 1'b0, 0);
      for (int c = 1; c <= 3; c++) begin
         @(negedge clk); #1 start = 1'b0;
      end
      #2 rst = 1'b1;
      sb.delete();
      #1;
      check1("async_a_valid", a_valid, 1'b0);
      check1("async_busy",    busy,    1'b0);
      check1("async_a",       a,       1'b0);
      check1("async_done",    done,    1'b0);
      check1("async_ready",   ready,   1'b1);
      @(negedge clk); #1 rst = 1'b0;
      step = "after_rst"; xfer(8'b0010_1101, 5'd6, 4'd1, 1'b0, 0, 0, 0);

      step = "len0";      xfer(8'b1111_1111, 5'd0,  4'd1, 1'b0, 0, 0, 0);
      step = "len20";     xfer(8'b1011_0010, 5'd20, 4'd1, 1'b0, 0, 0, 0);
      step = "rep0";      xfer(8'b0000_0101, 5'd3,  4'd0, 1'b0, 0, 0, 0);
      step = "rep0_gap";  xfer(8'b0000_0110, 5'd3,  4'd0, 1'b1, 0, 0, 0);
      step = "len1_rep2"; xfer(8'b0000_0001, 5'd1,  4'd2, 1'b1, 0, 0, 0);
      step = "rep15_gap"; xfer(8'b0000_0010, 5'd2,  4'd15, 1'b1, 1, 0, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
